// File: rtl/pipe_stage_skid_if.sv
// Valid/ready group channel for multi-lane pipeline stages.
// The producer drives valid/data and the consumer drives ready.
interface pipe_stage_skid_if #(
    parameter int LANES  = 2,
    parameter int LANE_W = 128
);
    logic [LANES-1:0]        valid;
    logic [LANES*LANE_W-1:0] data;
    logic                    ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Multi-lane pipeline stage with a one-group skid buffer, exception/branch flush
// and a saturating downstream-bubble counter.
module pipe_stage_skid #(
    parameter int LANES  = 2,
    parameter int LANE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    input  logic                flush_exc,
    input  logic                flush_br,
    input  logic [LANES-1:0]    flush_br_keep,
    output logic [CNT_W-1:0]    bubble_cnt
);
    localparam int DW = LANES * LANE_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_r;
    logic [LANES-1:0]   main_valid_r;
    logic [DW-1:0]      main_data_r;
    logic [LANES-1:0]   skid_valid_r;
    logic [DW-1:0]      skid_data_r;
    logic [CNT_W-1:0]   bubble_r;

    logic               in_ready_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic [LANES-1:0]   keep_valid_s;
    logic [DW-1:0]      in_data_nop_s;

    // Invalid lanes carry an all-zero payload so downstream sees NOPs.
    function automatic logic [DW-1:0] mask_lanes(input logic [DW-1:0] d,
                                                 input logic [LANES-1:0] v);
        logic [DW-1:0] m;
        m = d;
        for (int i = 0; i < LANES; i++) begin
            if (!v[i]) begin
                m[i*LANE_W +: LANE_W] = {LANE_W{1'b0}};
            end else begin
                m[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
            end
        end
        return m;
    endfunction

    // Handshake decode; in_ready depends on registered state only.
    always_comb begin
        in_ready_s    = (state_r != TWO) && !rst;
        in_fire_s     = (|up.valid) && in_ready_s;
        out_fire_s    = (|main_valid_r) && dn.ready;
        keep_valid_s  = main_valid_r & flush_br_keep;
        in_data_nop_s = mask_lanes(up.data, up.valid);
    end

    assign up.ready   = in_ready_s;
    assign dn.valid   = main_valid_r;
    assign dn.data    = main_data_r;
    assign bubble_cnt = bubble_r;

    // Stage FSM with main and skid registers.
    always_ff @(posedge clk) begin
        if (rst || flush_exc) begin
            state_r      <= EMPTY;
            main_valid_r <= {LANES{1'b0}};
            main_data_r  <= {DW{1'b0}};
            skid_valid_r <= {LANES{1'b0}};
            skid_data_r  <= {DW{1'b0}};
        end else if (flush_br) begin
            skid_valid_r <= {LANES{1'b0}};
            skid_data_r  <= {DW{1'b0}};
            if (out_fire_s || !(|keep_valid_s)) begin
                state_r      <= EMPTY;
                main_valid_r <= {LANES{1'b0}};
                main_data_r  <= {DW{1'b0}};
            end else begin
                state_r      <= ONE;
                main_valid_r <= keep_valid_s;
                main_data_r  <= mask_lanes(main_data_r, keep_valid_s);
            end
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        state_r      <= ONE;
                        main_valid_r <= up.valid;
                        main_data_r  <= in_data_nop_s;
                    end else begin
                        state_r      <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_valid_r <= up.valid;
                        main_data_r  <= in_data_nop_s;
                    end else if (in_fire_s) begin
                        state_r      <= TWO;
                        skid_valid_r <= up.valid;
                        skid_data_r  <= in_data_nop_s;
                    end else if (out_fire_s) begin
                        state_r      <= EMPTY;
                        main_valid_r <= {LANES{1'b0}};
                        main_data_r  <= {DW{1'b0}};
                    end else begin
                        state_r      <= ONE;
                    end
                end
                TWO: begin
                    if (out_fire_s) begin
                        state_r      <= ONE;
                        main_valid_r <= skid_valid_r;
                        main_data_r  <= skid_data_r;
                        skid_valid_r <= {LANES{1'b0}};
                        skid_data_r  <= {DW{1'b0}};
                    end else begin
                        state_r      <= TWO;
                    end
                end
                default: begin
                    state_r      <= EMPTY;
                    main_valid_r <= {LANES{1'b0}};
                    main_data_r  <= {DW{1'b0}};
                    skid_valid_r <= {LANES{1'b0}};
                    skid_data_r  <= {DW{1'b0}};
                end
            endcase
        end
    end

    // Saturating count of cycles where downstream was ready but got nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_r <= {CNT_W{1'b0}};
        end else if (dn.ready && !(|main_valid_r) && (bubble_r != {CNT_W{1'b1}})) begin
            bubble_r <= bubble_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_r <= bubble_r;
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, skid back-pressure, flushes,
// NOP lane zeroing, bubble saturation and mid-stream reset.
module tb_pipe_stage_skid;
    logic         clk = 1'b0;
    logic         rst;
    logic         flush_exc;
    logic         flush_br;
    logic [1:0]   flush_br_keep;
    logic [3:0]   bubble_cnt;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] da, db, dc, dd;

    pipe_stage_skid_if #(.LANES(2), .LANE_W(128)) up_if ();
    pipe_stage_skid_if #(.LANES(2), .LANE_W(128)) dn_if ();

    pipe_stage_skid #(.LANES(2), .LANE_W(128), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .up            (up_if.slave),
        .dn            (dn_if.master),
        .flush_exc     (flush_exc),
        .flush_br      (flush_br),
        .flush_br_keep (flush_br_keep),
        .bubble_cnt    (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [1:0] v, input logic [255:0] d);
        up_if.valid = v;
        up_if.data  = d;
    endtask

    initial begin
        da = {128'hA1A1_0000_0000_0000_0000_0000_0000_00A1, 128'hA0A0_0000_0000_0000_0000_0000_0000_00A0};
        db = {128'hB1B1_0000_0000_0000_0000_0000_0000_00B1, 128'hB0B0_0000_0000_0000_0000_0000_0000_00B0};
        dc = {128'hC1C1_0000_0000_0000_0000_0000_0000_00C1, 128'hC0C0_0000_0000_0000_0000_0000_0000_00C0};
        dd = {2{128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA}};

        rst = 1'b1; flush_exc = 1'b0; flush_br = 1'b0; flush_br_keep = 2'b00;
        offer(2'b00, 256'd0);
        dn_if.ready = 1'b0;
        step(); step();
        chk("rst_in_ready", {255'd0, up_if.ready}, 256'd0);
        chk("rst_out_valid", {254'd0, dn_if.valid}, 256'd0);
        chk("rst_bubble", {252'd0, bubble_cnt}, 256'd0);

        // 1: stream A, B, C with downstream always ready
        rst = 1'b0; dn_if.ready = 1'b1; offer(2'b11, da);
        step();
        chk("t1_out_a", dn_if.data, da);
        chk("t1_valid_a", {254'd0, dn_if.valid}, 256'd3);
        chk("t1_bubble_a", {252'd0, bubble_cnt}, 256'd1);
        chk("t1_in_ready_a", {255'd0, up_if.ready}, 256'd1);
        offer(2'b11, db); step();
        chk("t1_out_b", dn_if.data, db);
        chk("t1_in_ready_b", {255'd0, up_if.ready}, 256'd1);
        offer(2'b11, dc); step();
        chk("t1_out_c", dn_if.data, dc);
        chk("t1_bubble_c", {252'd0, bubble_cnt}, 256'd1);
        offer(2'b00, 256'd0); step();
        chk("t1_drain_valid", {254'd0, dn_if.valid}, 256'd0);
        chk("t1_drain_data", dn_if.data, 256'd0);

        // 2: back-pressure into skid, then drain in order
        dn_if.ready = 1'b0; offer(2'b11, da); step();
        offer(2'b11, db); step();
        chk("t2_two_in_ready", {255'd0, up_if.ready}, 256'd0);
        chk("t2_two_out_a", dn_if.data, da);
        offer(2'b11, dc); step();
        chk("t2_hold_out_a", dn_if.data, da);
        chk("t2_hold_in_ready", {255'd0, up_if.ready}, 256'd0);
        dn_if.ready = 1'b1; step();
        chk("t2_out_b", dn_if.data, db);
        chk("t2_in_ready_b", {255'd0, up_if.ready}, 256'd1);
        step();
        chk("t2_out_c", dn_if.data, dc);
        offer(2'b00, 256'd0); step();
        chk("t2_empty", {254'd0, dn_if.valid}, 256'd0);

        // 3: branch flush in TWO keeps lane0 only and drops skid
        dn_if.ready = 1'b0; offer(2'b11, da); step();
        offer(2'b11, db); step();
        offer(2'b11, dc); flush_br = 1'b1; flush_br_keep = 2'b01; step();
        chk("t3_valid", {254'd0, dn_if.valid}, 256'd1);
        chk("t3_data", dn_if.data, {128'd0, da[127:0]});
        chk("t3_in_ready", {255'd0, up_if.ready}, 256'd1);
        flush_br = 1'b0; flush_br_keep = 2'b00; offer(2'b00, 256'd0); dn_if.ready = 1'b1; step();
        chk("t3_skid_dropped", {254'd0, dn_if.valid}, 256'd0);

        // 4: both flushes in TWO with input offered
        dn_if.ready = 1'b0; offer(2'b11, da); step();
        offer(2'b11, db); step();
        offer(2'b11, dc); flush_exc = 1'b1; flush_br = 1'b1; flush_br_keep = 2'b11; step();
        chk("t4_valid", {254'd0, dn_if.valid}, 256'd0);
        chk("t4_data", dn_if.data, 256'd0);
        chk("t4_in_ready", {255'd0, up_if.ready}, 256'd1);
        flush_br = 1'b0; flush_br_keep = 2'b00;
        offer(2'b11, da); flush_exc = 1'b0; step();
        offer(2'b11, dc); flush_exc = 1'b1; step();
        chk("t4_exc_drops_input", {254'd0, dn_if.valid}, 256'd0);
        flush_exc = 1'b0;

        // 5: single-lane group zeroes the invalid lane; empty group is no transfer
        offer(2'b10, dd); step();
        chk("t5_valid", {254'd0, dn_if.valid}, 256'd2);
        chk("t5_data", dn_if.data, {dd[255:128], 128'd0});
        offer(2'b00, db); dn_if.ready = 1'b1; step();
        chk("t5_no_xfer_valid", {254'd0, dn_if.valid}, 256'd0);
        chk("t5_no_xfer_data", dn_if.data, 256'd0);

        // 6: bubble saturation at 15, then reset mid-stream
        rst = 1'b1; step();
        rst = 1'b0; offer(2'b00, 256'd0); dn_if.ready = 1'b1;
        for (int i = 0; i < 14; i++) step();
        chk("t6_bubble_14", {252'd0, bubble_cnt}, 256'd14);
        for (int i = 0; i < 6; i++) step();
        chk("t6_bubble_sat", {252'd0, bubble_cnt}, 256'd15);
        offer(2'b11, da); step();
        chk("t6_stream_a", dn_if.data, da);
        offer(2'b11, db); rst = 1'b1; step();
        chk("t6_rst_valid", {254'd0, dn_if.valid}, 256'd0);
        chk("t6_rst_data", dn_if.data, 256'd0);
        chk("t6_rst_bubble", {252'd0, bubble_cnt}, 256'd0);
        chk("t6_rst_in_ready", {255'd0, up_if.ready}, 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
